sha2_msg_sched: RTL and testbench
=================================

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 32, word width; 32 selects SHA-256, 64 selects SHA-512; other values rejected at elaboration.
REQ-002 SHALL have localparam ROUNDS: 64 when WORD_W=32, 80 when WORD_W=64.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 blk_valid  in  1  blk_data offered.
REQ-007 blk_ready  out  1  block can be accepted this cycle.
REQ-008 blk_data  in  16*WORD_W  message block; word 0 = blk_data[16*WORD_W-1 -: WORD_W] (big-endian).
REQ-009 w_valid  out  1  w_data/w_idx/w_last valid.
REQ-010 w_ready  in  1  consumer accepts word.
REQ-011 w_data  out  WORD_W  schedule word W[w_idx].
REQ-012 w_idx  out  7  round index 0..ROUNDS-1.
REQ-013 w_last  out  1  high with w_idx=ROUNDS-1.
REQ-014 busy  out  1  high while a block is being scheduled.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; blk_ready=1 in IDLE, w_valid=1 and busy=1 in RUN.
REQ-016 Block handshake = blk_valid&&blk_ready; on it, 16-entry window win[0..15] <= block words 0..15, idx <= 0, state <= RUN.
REQ-017 In RUN, w_data SHALL equal win[0] and w_idx SHALL equal idx, both registered (no combinational path from inputs).
REQ-018 Word handshake = w_valid&&w_ready; on it window shifts down (win[i] <= win[i+1]) and win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^WORD_W, idx <= idx+1.
REQ-019 WORD_W=32: s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10.
REQ-020 WORD_W=64: s0 = ROTR1^ROTR8^SHR7, s1 = ROTR19^ROTR61^SHR6.
REQ-021 Latency: first word (w_idx=0) valid the cycle after block handshake; one word per cycle while w_ready=1.
REQ-022 With w_ready=0, w_data, w_idx, w_last, window SHALL hold unchanged.
REQ-023 Handshake on w_last SHALL return FSM to IDLE (subject to REQ-030).
REQ-024 blk_data is sampled only at block handshake; changes at other times SHALL be ignored.
REQ-025 In IDLE, w_valid=0, w_last=0; w_data and w_idx hold last values.

Reset
REQ-026 rst=1 at rising edge SHALL force IDLE from any state, including mid-RUN, discarding the block.
REQ-027 Post-reset values: blk_ready=1, w_valid=0, w_last=0, busy=0, w_idx=0, w_data=0, all window entries 0.
REQ-028 While rst=1, blk_valid and w_ready SHALL be ignored.

Configuration
REQ-029 Macro SHA2_MSG_SCHED_B2B_EN SHALL select back-to-back block acceptance.
REQ-030 Defined: blk_ready also =1 in RUN when w_last=1 && w_ready=1; simultaneous last-word and block handshakes load the new block, stay RUN, idx <= 0, zero bubble.
REQ-031 Undefined: blk_ready=0 throughout RUN; at least one IDLE cycle separates consecutive blocks.

Verification
REQ-032 WORD_W=32, "abc" padded block (W0=0x61626380, W15=0x00000018, others 0), w_ready=1 -> W16=0x61626380, W17=0x000F0000, 64 words, w_last only at w_idx=63, w_valid one cycle after accept.
REQ-033 WORD_W=64, "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, w_last at w_idx=79.
REQ-034 Random w_ready backpressure on REQ-032 stimulus -> identical word sequence to free-running case; outputs stable while w_ready=0.
REQ-035 Assert rst at w_idx=20 -> next cycle w_valid=0, blk_ready=1, w_idx=0, w_data=0; new block then schedules from w_idx=0.
REQ-036 Two blocks with blk_valid held, w_ready=1 -> with B2B_EN second block's w_idx=0 immediately follows w_idx=63; without, exactly one cycle w_valid=0 between.

Source files
------------

// File: rtl/sha2_msg_sched.sv
// SHA-256/512 message schedule: loads a 16-word block and streams W[0..ROUNDS-1]; SHA2_MSG_SCHED_B2B_EN allows back-to-back blocks.
// Latency: W[0] is valid the cycle after the block handshake, then one word per accepted cycle.
// Backpressure: w_ready=0 freezes outputs and window; blk_ready is low while a block is running.
module sha2_msg_sched #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  blk_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [6:0]            w_idx,
  output logic                  w_last,
  output logic                  busy
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_msg_sched: WORD_W must be 32 or 64");
    end
  endgenerate

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [0:0]                 state;
  logic [6:0]                 idx;
  logic [15:0][WORD_W-1:0]    win;
  logic [WORD_W-1:0]          w_new;
  logic                       blk_hs;
  logic                       w_hs;

  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign w_last  = (state == RUN) && (idx == 7'(ROUNDS - 1));
  assign w_data  = win[0];
  assign w_idx   = idx;

`ifdef SHA2_MSG_SCHED_B2B_EN
  assign blk_ready = (state == IDLE) || (w_last && w_ready);
`else
  assign blk_ready = (state == IDLE);
`endif

  assign blk_hs = blk_valid && blk_ready;
  assign w_hs   = w_valid && w_ready;
  assign w_new  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // The window is not shifted on the last word so w_data keeps W[ROUNDS-1] in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      win   <= '0;
    end else if (blk_hs) begin
      for (int i = 0; i < 16; i++)
        win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
      idx   <= '0;
      state <= RUN;
    end else if (w_hs) begin
      if (w_last) begin
        state <= IDLE;
      end else begin
        for (int i = 0; i < 15; i++)
          win[i] <= win[i+1];
        win[15] <= w_new;
        idx     <= idx + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Directed bench for sha2_msg_sched: "abc" vectors for both widths, backpressure, mid-run reset, block spacing.
module tb_sha2_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         bv32, br32, wv32, wr32, wl32, busy32;
  logic [511:0] bd32;
  logic [31:0]  wd32;
  logic [6:0]   wi32;
  logic          bv64, br64, wv64, wr64, wl64, busy64;
  logic [1023:0] bd64;
  logic [63:0]   wd64;
  logic [6:0]    wi64;

  sha2_msg_sched #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .blk_valid(bv32), .blk_ready(br32), .blk_data(bd32),
    .w_valid(wv32), .w_ready(wr32), .w_data(wd32), .w_idx(wi32), .w_last(wl32), .busy(busy32)
  );

  sha2_msg_sched #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .blk_valid(bv64), .blk_ready(br64), .blk_data(bd64),
    .w_valid(wv64), .w_ready(wr64), .w_data(wd64), .w_idx(wi64), .w_last(wl64), .busy(busy64)
  );

  typedef struct {
    bit          wide;
    int          idx;
    logic [63:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got32 [64];
  logic [31:0] m32   [64];
  logic [63:0] got64 [80];
  logic [63:0] m64   [80];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  task automatic model32(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) m32[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      m32[t] = (r32(m32[t-2], 17) ^ r32(m32[t-2], 19) ^ (m32[t-2] >> 10)) + m32[t-7]
             + (r32(m32[t-15], 7) ^ r32(m32[t-15], 18) ^ (m32[t-15] >> 3)) + m32[t-16];
  endtask

  task automatic model64(input logic [1023:0] blk);
    for (int t = 0; t < 16; t++) m64[t] = blk[1023-64*t -: 64];
    for (int t = 16; t < 80; t++)
      m64[t] = (r64(m64[t-2], 19) ^ r64(m64[t-2], 61) ^ (m64[t-2] >> 6)) + m64[t-7]
             + (r64(m64[t-15], 1) ^ r64(m64[t-15], 8) ^ (m64[t-15] >> 7)) + m64[t-16];
  endtask

  // Accept one block on the 32-bit instance and drain all 64 words, optionally with random stalls.
  task automatic send32(input logic [511:0] blk, input bit bp);
    int k;
    int cyc;
    logic [31:0] pd;
    logic [6:0]  pi;
    model32(blk);
    chk("idle_ready32", 64'(br32), 64'd1);
    chk("idle_valid32", 64'(wv32), 64'd0);
    bd32 = blk; bv32 = 1'b1; wr32 = 1'b1;
    tick();
    bv32 = 1'b0; bd32 = {16{32'hDEADBEEF}};
    chk("first_valid32", 64'(wv32), 64'd1);
    chk("first_busy32", 64'(busy32), 64'd1);
    k = 0; cyc = 0;
    while (k < 64 && cyc < 2000) begin
      wr32 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pd = wd32; pi = wi32;
      if (!wv32) begin
        chk("valid_drop32", 64'(wv32), 64'd1);
        break;
      end
      chk("idx32", 64'(wi32), 64'(k));
      chk("last32", 64'(wl32), 64'(k == 63));
      if (wr32) got32[k] = wd32;
      tick();
      cyc++;
      if (wr32) k++;
      else begin
        chk("stall_data32", 64'(wd32), 64'(pd));
        chk("stall_idx32", 64'(wi32), 64'(pi));
      end
    end
    wr32 = 1'b0;
    if (k < 64) chk("timeout32", 64'(k), 64'd64);
    chk("end_idle32", 64'(wv32), 64'd0);
    chk("end_last32", 64'(wl32), 64'd0);
    chk("hold_data32", 64'(wd32), 64'(m32[63]));
    chk("hold_idx32", 64'(wi32), 64'd63);
    for (int t = 0; t < 64; t++) chk("word32", 64'(got32[t]), 64'(m32[t]));
  endtask

  task automatic send64(input logic [1023:0] blk);
    int k;
    model64(blk);
    bd64 = blk; bv64 = 1'b1; wr64 = 1'b1;
    tick();
    bv64 = 1'b0; bd64 = '1;
    chk("first_valid64", 64'(wv64), 64'd1);
    k = 0;
    while (k < 80 && wv64) begin
      chk("idx64", 64'(wi64), 64'(k));
      chk("last64", 64'(wl64), 64'(k == 79));
      got64[k] = wd64;
      tick();
      k++;
    end
    wr64 = 1'b0;
    chk("count64", 64'(k), 64'd80);
    chk("end_idle64", 64'(wv64), 64'd0);
    for (int t = 0; t < 80; t++) chk("word64", got64[t], m64[t]);
  endtask

  initial begin
    vec_t         tbl [10];
    logic [511:0] abc32, rb, rb2;
    logic [1023:0] abc64;
    int           cyc;

    abc32 = {32'h61626380, {14{32'h0}}, 32'h18};
    abc64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
    for (int i = 0; i < 16; i++) begin
      rb[i*32 +: 32]  = $urandom;
      rb2[i*32 +: 32] = $urandom;
    end
    tbl[0] = '{1'b0, 0,  64'h61626380};
    tbl[1] = '{1'b0, 1,  64'h0};
    tbl[2] = '{1'b0, 15, 64'h18};
    tbl[3] = '{1'b0, 16, 64'h61626380};
    tbl[4] = '{1'b0, 17, 64'h000F0000};
    tbl[5] = '{1'b1, 0,  64'h6162638000000000};
    tbl[6] = '{1'b1, 1,  64'h0};
    tbl[7] = '{1'b1, 15, 64'h18};
    tbl[8] = '{1'b1, 16, 64'h6162638000000000};
    tbl[9] = '{1'b1, 17, 64'h00030000000000C0};

    // Reset, with blk_valid and w_ready asserted to show they are ignored.
    rst = 1'b1; bv32 = 1'b1; bd32 = abc32; wr32 = 1'b1;
    bv64 = 1'b1; bd64 = abc64; wr64 = 1'b1;
    tick(); tick();
    chk("rst_ready32", 64'(br32), 64'd1);
    chk("rst_valid32", 64'(wv32), 64'd0);
    chk("rst_last32", 64'(wl32), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_idx32", 64'(wi32), 64'd0);
    chk("rst_data32", 64'(wd32), 64'd0);
    chk("rst_ready64", 64'(br64), 64'd1);
    chk("rst_valid64", 64'(wv64), 64'd0);
    chk("rst_busy64", 64'(busy64), 64'd0);
    chk("rst_data64", wd64, 64'd0);
    bv32 = 1'b0; wr32 = 1'b0; bv64 = 1'b0; wr64 = 1'b0;
    rst = 1'b0;
    tick();

    send32(abc32, 1'b0);
    send64(abc64);
    for (int i = 0; i < 10; i++)
      chk($sformatf("tbl%0d_w%0d", i, tbl[i].idx),
          tbl[i].wide ? got64[tbl[i].idx] : 64'(got32[tbl[i].idx]), tbl[i].exp);

    tick();
    send32(abc32, 1'b1);

    // Reset in the middle of a block.
    tick();
    bd32 = abc32; bv32 = 1'b1; wr32 = 1'b1;
    tick();
    bv32 = 1'b0;
    cyc = 0;
    while (wi32 != 7'd20 && cyc < 100) begin tick(); cyc++; end
    chk("reach20", 64'(wi32), 64'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0; wr32 = 1'b0;
    chk("mid_rst_valid", 64'(wv32), 64'd0);
    chk("mid_rst_ready", 64'(br32), 64'd1);
    chk("mid_rst_idx", 64'(wi32), 64'd0);
    chk("mid_rst_data", 64'(wd32), 64'd0);
    chk("mid_rst_busy", 64'(busy32), 64'd0);
    send32(rb, 1'b0);

    // Two blocks with blk_valid held throughout.
    tick();
    model32(rb2);
    bd32 = abc32; bv32 = 1'b1; wr32 = 1'b1;
    tick();
    bd32 = rb2;
    cyc = 0;
    while (!(wv32 && wi32 == 7'd63) && cyc < 200) begin tick(); cyc++; end
    chk("b2b_reach63", 64'(wi32), 64'd63);
    tick();
`ifdef SHA2_MSG_SCHED_B2B_EN
    chk("b2b_valid", 64'(wv32), 64'd1);
    chk("b2b_idx", 64'(wi32), 64'd0);
    chk("b2b_data", 64'(wd32), 64'(m32[0]));
    bv32 = 1'b0;
`else
    chk("gap_valid", 64'(wv32), 64'd0);
    chk("gap_ready", 64'(br32), 64'd1);
    tick();
    chk("gap_next_valid", 64'(wv32), 64'd1);
    chk("gap_next_idx", 64'(wi32), 64'd0);
    chk("gap_next_data", 64'(wd32), 64'(m32[0]));
    bv32 = 1'b0;
`endif
    cyc = 0;
    while (wv32 && cyc < 200) begin
      got32[wi32[5:0]] = wd32;
      tick();
      cyc++;
    end
    wr32 = 1'b0;
    chk("second_blk_len", 64'(cyc), 64'd64);
    for (int t = 0; t < 64; t++) chk("second_blk_word", 64'(got32[t]), 64'(m32[t]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
